hilo_ctrl: RTL and testbench
============================

# hilo_ctrl

Multi-cycle MULT/DIV sequencer that owns the architectural HI/LO registers of the core. It accepts a multiply, divide or move-to-HI/LO request from the EX stage, stalls EX while the operation is in flight, commits the result to HI/LO, and drives the HI/LO values consumed by MFHI/MFLO and by the write-back forwarding mux. A pipeline flush aborts an in-flight operation with no architectural side effect.

## Interface
- DIV_ITER, 32: radix-2 divide iterations; fixed to the operand width.
- clk  in  1  core clock; all state updates on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- ex_req  in  1  EX holds a valid HI/LO-writing instruction.
- ex_op  in  3  operation: MULT, MULTU, DIV, DIVU, MTHI, MTLO (encodings in package).
- ex_a  in  32  rs operand (dividend / multiplicand / MTHI-MTLO data).
- ex_b  in  32  rt operand (divisor / multiplier).
- cancel  in  1  flush from a MEM/WB exception or ERET; kills the current request and any in-flight operation.
- ex_stall  out  1  EX must hold; high while a MULT/DIV request has not completed.
- done  out  1  one-cycle pulse: HI/LO were updated by a MULT/DIV at the preceding edge.
- hi  out  32  HI register.
- lo  out  32  LO register.

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE, ex_req && !cancel:
  - MTHI/MTLO: write hi/lo from ex_a at the edge; remain in IDLE; no stall.
  - MULT/MULTU: latch operands, go to MUL.
  - DIV/DIVU: latch operand magnitudes (signed ops take absolute values), clear the partial remainder, load a 6-bit counter with DIV_ITER, go to DIV.
- MUL: form the 64-bit signed or unsigned product of the latched operands; {hi,lo} <= product; go to DONE.
- DIV: one restoring step per cycle: shift the remainder left, subtract the divisor and, if non-negative, keep the difference and set the quotient bit. Decrement the counter. At counter == 1, write sign-corrected results (lo = quotient, hi = remainder) and go to DONE.
- Sign rules for DIV: quotient negated iff a[31]^b[31]; remainder takes the sign of the dividend. 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- Divide by zero follows the natural restoring result: quotient magnitude 0xFFFFFFFF, remainder magnitude |a|, then sign correction. DIVU x/0 gives lo=0xFFFFFFFF, hi=x.
- DONE: done=1, ex_stall=0, new requests are ignored; always go to IDLE. EX advances this cycle, so the next instruction is seen in IDLE.
- ex_stall = ex_req && op∈{MULT,MULTU,DIV,DIVU} && state≠DONE && !cancel.
- cancel has priority in every state: go to IDLE next edge, no hi/lo write, and ex_stall=0 combinationally in the same cycle.

## Timing
- Reset: state=IDLE, hi=0, lo=0, counter=0, done=0, ex_stall=0.
- MULT latency: request in cycle 0 (IDLE), MUL in cycle 1, hi/lo valid and done=1 in cycle 2. EX stalls for 2 cycles.
- DIV latency: accepted in cycle 0, DIV in cycles 1–32, hi/lo valid and done=1 in cycle 33. EX stalls for 33 cycles.
- MTHI/MTLO: hi/lo visible in the cycle after the request.
- hi/lo are plain register outputs with no combinational path from the inputs.
- Reset asserted mid-operation returns everything to the reset values immediately.

## Structure
- hilo_pkg: ex_op encodings, state enum, DIV_ITER constant.
- Sub-module div_step: combinational restoring step, (rem, quot, divisor) to (rem', quot'). Instantiated once; the sequencer registers its output.
- The multiplier is an inferred 33x33 signed multiply with sign/zero extension chosen by MULT/MULTU.

## Test plan
- MULT a=0xFFFFFFFE (-2), b=3: ex_stall high for 2 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulses once. MULTU with the same operands gives hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=-7, b=2: stall for 33 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 gives lo=14, hi=2.
- Corner divides: DIV 0x80000000/0xFFFFFFFF gives lo=0x80000000, hi=0. DIVU 5/0 gives lo=0xFFFFFFFF, hi=5.
- cancel at DIV cycle 10: IDLE next cycle, hi/lo unchanged from the prior values, no done pulse, ex_stall drops in the cancel cycle.
- Back-to-back MTHI 0x1234 then MTLO 0x5678 with no stall, then MULT: hi/lo are overwritten only at done. MTLO asserted with cancel leaves lo unchanged.
- Assert reset at DIV cycle 20: hi=lo=0 and state=IDLE immediately. The first request after release is accepted normally.

Source files
------------

// File: rtl/hilo_pkg.sv
// HI/LO sequencer shared definitions: operation encodings, FSM states, divide length.
// Pure declarations; no logic and no latency of its own.
// No flow control here; the sequencer applies backpressure through ex_stall.
package hilo_pkg;

  localparam int DIV_ITER = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } hilo_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } hilo_state_e;

  // True for the operations that occupy the sequencer for more than one cycle.
  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Magnitude of v when interpreted as signed (sgn=1), else v unchanged.
  // 0x80000000 maps to itself, which is the correct unsigned magnitude.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift remainder/quotient left, trial-subtract the divisor.
// Purely combinational, zero latency; the sequencer registers the result.
// No backpressure; evaluated every cycle and used only while dividing.
module div_step (
  input  logic [31:0] i_rem,
  input  logic [31:0] i_quot,
  input  logic [31:0] i_dvsr,
  output logic [31:0] o_rem,
  output logic [31:0] o_quot
);

  logic [32:0] w_shift;
  logic [32:0] w_diff;

  // The remainder stays below the divisor, so 33 bits hold the shifted value and the
  // borrow bit of the trial subtraction is a reliable sign.
  assign w_shift = {i_rem, i_quot[31]};
  assign w_diff  = w_shift - {1'b0, i_dvsr};

  // Keep the difference and set the quotient bit when the subtraction did not borrow.
  always_comb begin
    o_rem  = w_shift[31:0];
    o_quot = {i_quot[30:0], 1'b0};
    if (!w_diff[32]) begin
      o_rem     = w_diff[31:0];
      o_quot[0] = 1'b1;
    end
  end

endmodule

// File: rtl/hilo_ctrl.sv
// MULT/DIV sequencer owning HI/LO; MTHI/MTLO write in one cycle.
// Latency: MULT 2 cycles to done, DIV 33 cycles to done.
// Backpressure: ex_stall holds EX until done; cancel aborts with no HI/LO write.
module hilo_ctrl
  import hilo_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_req,
  input  logic [2:0]  ex_op,
  input  logic [31:0] ex_a,
  input  logic [31:0] ex_b,
  input  logic        cancel,
  output logic        ex_stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  hilo_state_e        r_state;
  hilo_state_e        w_state_nxt;
  logic [31:0]        r_a;       // multiplicand, or dividend/quotient shift register
  logic [31:0]        r_b;       // multiplier, or divisor magnitude
  logic [31:0]        r_rem;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;
  logic [5:0]         r_cnt;
  logic               r_signed;
  logic               r_neg_q;
  logic               r_neg_r;

  logic               w_go;
  logic               w_dsgn;
  logic signed [32:0] w_ma;
  logic signed [32:0] w_mb;
  logic signed [63:0] w_prod;
  logic [31:0]        w_rem_nxt;
  logic [31:0]        w_quot_nxt;
  logic [31:0]        w_q_fin;
  logic [31:0]        w_r_fin;

  assign w_go   = ex_req && !cancel;
  assign w_dsgn = (ex_op == OP_DIV);

  // 33-bit operands let one signed multiplier serve both MULT and MULTU.
  assign w_ma   = {r_signed & r_a[31], r_a};
  assign w_mb   = {r_signed & r_b[31], r_b};
  assign w_prod = 64'(w_ma) * 64'(w_mb);

  div_step u_div_step (
    .i_rem  (r_rem),
    .i_quot (r_a),
    .i_dvsr (r_b),
    .o_rem  (w_rem_nxt),
    .o_quot (w_quot_nxt)
  );

  assign w_q_fin = r_neg_q ? (~w_quot_nxt + 32'd1) : w_quot_nxt;
  assign w_r_fin = r_neg_r ? (~w_rem_nxt + 32'd1) : w_rem_nxt;

  assign hi = r_hi;
  assign lo = r_lo;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next state, stall and done; cancel forces IDLE from any state.
  always_comb begin
    w_state_nxt = r_state;
    done        = 1'b0;
    ex_stall    = ex_req && is_muldiv(ex_op) && (r_state != ST_DONE) && !cancel;
    case (r_state)
      ST_IDLE: begin
        if (w_go) begin
          if ((ex_op == OP_MULT) || (ex_op == OP_MULTU))    w_state_nxt = ST_MUL;
          else if ((ex_op == OP_DIV) || (ex_op == OP_DIVU)) w_state_nxt = ST_DIV;
        end
      end
      ST_MUL:  w_state_nxt = cancel ? ST_IDLE : ST_DONE;
      ST_DIV: begin
        if (cancel)              w_state_nxt = ST_IDLE;
        else if (r_cnt == 6'd1)  w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Operand capture, divide iteration and HI/LO commit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_a      <= '0;
      r_b      <= '0;
      r_rem    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_cnt    <= '0;
      r_signed <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_go) begin
            case (ex_op)
              OP_MTHI: r_hi <= ex_a;
              OP_MTLO: r_lo <= ex_a;
              OP_MULT, OP_MULTU: begin
                r_a      <= ex_a;
                r_b      <= ex_b;
                r_signed <= (ex_op == OP_MULT);
              end
              OP_DIV, OP_DIVU: begin
                r_a     <= mag32(ex_a, w_dsgn);
                r_b     <= mag32(ex_b, w_dsgn);
                r_rem   <= '0;
                r_cnt   <= 6'(DIV_ITER);
                r_neg_q <= w_dsgn && (ex_a[31] ^ ex_b[31]);
                r_neg_r <= w_dsgn && ex_a[31];
              end
              default: ;
            endcase
          end
        end
        ST_MUL: begin
          if (!cancel) {r_hi, r_lo} <= w_prod;
        end
        ST_DIV: begin
          if (!cancel) begin
            r_rem <= w_rem_nxt;
            r_a   <= w_quot_nxt;
            r_cnt <= r_cnt - 6'd1;
            if (r_cnt == 6'd1) begin
              r_lo <= w_q_fin;
              r_hi <= w_r_fin;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_ctrl.sv
// Self-checking bench for hilo_ctrl: directed MULT/DIV/MT vectors, cancel and mid-op reset.
// Expected HI/LO pairs go into a scoreboard queue at issue and are popped at completion.
// Inputs are driven and outputs sampled around the falling clock edge.
module tb_hilo_ctrl;
  import hilo_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ex_req;
  logic [2:0]  ex_op;
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic        cancel;
  logic        ex_stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks   = 0;
  int failures = 0;

  logic [63:0] sb_q[$];

  hilo_ctrl dut (
    .clk      (clk),
    .resetn   (resetn),
    .ex_req   (ex_req),
    .ex_op    (ex_op),
    .ex_a     (ex_a),
    .ex_b     (ex_b),
    .cancel   (cancel),
    .ex_stall (ex_stall),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  // Reference {hi,lo} built from native operators.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    logic [31:0] q;
    logic [31:0] m;
    r = '0;
    case (op)
      OP_MULT:  r = 64'($signed(a)) * 64'($signed(b));
      OP_MULTU: r = {32'd0, a} * {32'd0, b};
      OP_DIVU:  r = (b == 32'd0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
      OP_DIV: begin
        if (b == 32'd0) r = {a, (a[31] ? 32'd1 : 32'hFFFFFFFF)};
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = {32'd0, 32'h80000000};
        else begin
          q = $signed(a) / $signed(b);
          m = $signed(a) % $signed(b);
          r = {m, q};
        end
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Drive one MULT/DIV request (called just after a falling edge) and hold it until
  // the stall drops; report the stall count, any early done, and the final outputs.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int stalls, output int early_done, output logic fin_done,
                        output logic [31:0] fhi, output logic [31:0] flo, output logic timed_out);
    stalls = 0; early_done = 0; fin_done = 1'b0; fhi = '0; flo = '0; timed_out = 1'b1;
    ex_req = 1'b1; ex_op = op; ex_a = a; ex_b = b;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (ex_stall) begin
        stalls++;
        if (done) early_done++;
      end else begin
        fin_done = done; fhi = hi; flo = lo; timed_out = 1'b0;
        break;
      end
      @(negedge clk);
    end
    ex_req = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; ex_req = 1'b0; ex_op = OP_MULT; ex_a = '0; ex_b = '0; cancel = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk); #1;
    checks++; if (hi !== 32'd0)   begin failures++; $display("FAIL reset_hi: got %h want 0", hi); end
    checks++; if (lo !== 32'd0)   begin failures++; $display("FAIL reset_lo: got %h want 0", lo); end
    checks++; if (done !== 1'b0)  begin failures++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (ex_stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b want 0", ex_stall); end
  endtask

  task automatic test_mult();
    logic [2:0]  ops[4];
    logic [31:0] as[4];
    logic [31:0] bs[4];
    logic [63:0] consts[2];
    logic [63:0] exp_v;
    int st, ed;
    logic fd, to;
    logic [31:0] fh, fl;
    ops[0] = OP_MULT;  as[0] = 32'hFFFFFFFE; bs[0] = 32'd3;
    ops[1] = OP_MULTU; as[1] = 32'hFFFFFFFE; bs[1] = 32'd3;
    ops[2] = OP_MULT;  as[2] = $urandom;     bs[2] = $urandom;
    ops[3] = OP_MULTU; as[3] = $urandom;     bs[3] = $urandom;
    consts[0] = {32'hFFFFFFFF, 32'hFFFFFFFA};
    consts[1] = {32'h00000002, 32'hFFFFFFFA};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sb_q.push_back((i < 2) ? consts[i] : model(ops[i], as[i], bs[i]));
      run_op(ops[i], as[i], bs[i], st, ed, fd, fh, fl, to);
      exp_v = sb_q.pop_front();
      checks++; if (to)       begin failures++; $display("FAIL mult%0d_timeout: stall never dropped", i); end
      checks++; if (st != 2)  begin failures++; $display("FAIL mult%0d_stall: got %0d cycles want 2", i, st); end
      checks++; if (ed != 0 || fd !== 1'b1) begin failures++; $display("FAIL mult%0d_done: early=%0d final=%b want 0/1", i, ed, fd); end
      checks++; if ({fh, fl} !== exp_v) begin failures++; $display("FAIL mult%0d_hilo: got %h want %h", i, {fh, fl}, exp_v); end
      @(negedge clk); #1;
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL mult%0d_done_once: got %b want 0", i, done); end
    end
  endtask

  task automatic test_div();
    logic [2:0]  ops[7];
    logic [31:0] as[7];
    logic [31:0] bs[7];
    logic [63:0] consts[4];
    logic [63:0] exp_v;
    int st, ed;
    logic fd, to;
    logic [31:0] fh, fl;
    ops[0] = OP_DIV;  as[0] = 32'hFFFFFFF9; bs[0] = 32'd2;
    ops[1] = OP_DIVU; as[1] = 32'd100;      bs[1] = 32'd7;
    ops[2] = OP_DIV;  as[2] = 32'h80000000; bs[2] = 32'hFFFFFFFF;
    ops[3] = OP_DIVU; as[3] = 32'd5;        bs[3] = 32'd0;
    ops[4] = OP_DIV;  as[4] = $urandom;     bs[4] = $urandom_range(1, 1000);
    ops[5] = OP_DIV;  as[5] = $urandom;     bs[5] = -$urandom_range(1, 70000);
    ops[6] = OP_DIVU; as[6] = $urandom;     bs[6] = $urandom;
    consts[0] = {32'hFFFFFFFF, 32'hFFFFFFFD};
    consts[1] = {32'd2, 32'd14};
    consts[2] = {32'd0, 32'h80000000};
    consts[3] = {32'd5, 32'hFFFFFFFF};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      sb_q.push_back((i < 4) ? consts[i] : model(ops[i], as[i], bs[i]));
      run_op(ops[i], as[i], bs[i], st, ed, fd, fh, fl, to);
      exp_v = sb_q.pop_front();
      checks++; if (to)       begin failures++; $display("FAIL div%0d_timeout: stall never dropped", i); end
      checks++; if (st != 33) begin failures++; $display("FAIL div%0d_stall: got %0d cycles want 33", i, st); end
      checks++; if (ed != 0 || fd !== 1'b1) begin failures++; $display("FAIL div%0d_done: early=%0d final=%b want 0/1", i, ed, fd); end
      checks++; if ({fh, fl} !== exp_v) begin failures++; $display("FAIL div%0d_hilo: got %h want %h", i, {fh, fl}, exp_v); end
      @(negedge clk); #1;
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL div%0d_done_once: got %b want 0", i, done); end
    end
  endtask

  task automatic test_cancel();
    logic [31:0] prior_hi;
    int spurious;
    @(negedge clk); #1;
    prior_hi = hi;
    ex_req = 1'b1; ex_op = OP_DIV; ex_a = 32'd100; ex_b = 32'd3;   // cycle 0
    repeat (9) @(negedge clk);                                      // cycle 9
    #1;
    checks++; if (ex_stall !== 1'b1) begin failures++; $display("FAIL cancel_prestall: got %b want 1", ex_stall); end
    @(negedge clk);                                                 // cycle 10
    cancel = 1'b1; #1;
    checks++; if (ex_stall !== 1'b0) begin failures++; $display("FAIL cancel_stall_drop: got %b want 0", ex_stall); end
    @(negedge clk);                                                 // cycle 11: must be IDLE
    cancel = 1'b0; ex_op = OP_MTLO; ex_a = 32'h0BADF00D; #1;
    checks++; if (hi !== prior_hi) begin failures++; $display("FAIL cancel_hi_kept: got %h want %h", hi, prior_hi); end
    @(negedge clk);
    ex_req = 1'b0; #1;
    checks++; if (lo !== 32'h0BADF00D) begin failures++; $display("FAIL cancel_idle_mtlo: got %h want 0badf00d", lo); end
    spurious = 0;
    repeat (30) begin
      @(negedge clk); #1;
      if (done) spurious++;
    end
    checks++; if (spurious != 0 || hi !== prior_hi) begin failures++; $display("FAIL cancel_no_commit: done_pulses=%0d hi=%h want 0/%h", spurious, hi, prior_hi); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_v;
    @(negedge clk);
    ex_req = 1'b1; ex_op = OP_MTHI; ex_a = 32'h1234; #1;
    checks++; if (ex_stall !== 1'b0) begin failures++; $display("FAIL b2b_mthi_stall: got %b want 0", ex_stall); end
    @(negedge clk);
    ex_op = OP_MTLO; ex_a = 32'h5678; #1;
    checks++; if (hi !== 32'h1234) begin failures++; $display("FAIL b2b_mthi: got %h want 00001234", hi); end
    @(negedge clk);                                                 // MULT cycle 0
    ex_op = OP_MULT; ex_a = 32'd1000; ex_b = 32'hFFFFFFF0;
    sb_q.push_back(model(OP_MULT, 32'd1000, 32'hFFFFFFF0));
    #1;
    checks++; if (lo !== 32'h5678 || ex_stall !== 1'b1) begin failures++; $display("FAIL b2b_mtlo: lo=%h stall=%b want 00005678/1", lo, ex_stall); end
    @(negedge clk); #1;                                             // MULT cycle 1
    checks++; if (hi !== 32'h1234 || lo !== 32'h5678) begin failures++; $display("FAIL b2b_hold: got %h_%h want 00001234_00005678", hi, lo); end
    @(negedge clk); #1;                                             // MULT cycle 2
    exp_v = sb_q.pop_front();
    checks++; if (done !== 1'b1 || ex_stall !== 1'b0) begin failures++; $display("FAIL b2b_done: done=%b stall=%b want 1/0", done, ex_stall); end
    checks++; if ({hi, lo} !== exp_v) begin failures++; $display("FAIL b2b_mult: got %h want %h", {hi, lo}, exp_v); end
    ex_req = 1'b0;
    @(negedge clk);
    ex_req = 1'b1; ex_op = OP_MTLO; ex_a = 32'hDEADBEEF; cancel = 1'b1;
    @(negedge clk);
    ex_req = 1'b0; cancel = 1'b0; #1;
    checks++; if (lo !== exp_v[31:0]) begin failures++; $display("FAIL mtlo_cancel: got %h want %h", lo, exp_v[31:0]); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] exp_v;
    int st, ed;
    logic fd, to;
    logic [31:0] fh, fl;
    @(negedge clk);
    ex_req = 1'b1; ex_op = OP_DIV; ex_a = 32'd1000; ex_b = 32'd7;   // cycle 0
    repeat (20) @(negedge clk);                                     // cycle 20
    resetn = 1'b0; ex_req = 1'b0; #1;
    checks++; if (hi !== 32'd0 || lo !== 32'd0) begin failures++; $display("FAIL rst_mid_hilo: got %h_%h want 0_0", hi, lo); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_mid_done: got %b want 0", done); end
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    sb_q.push_back(model(OP_MULTU, 32'd7, 32'd6));
    run_op(OP_MULTU, 32'd7, 32'd6, st, ed, fd, fh, fl, to);
    exp_v = sb_q.pop_front();
    checks++; if (to || st != 2 || fd !== 1'b1) begin failures++; $display("FAIL rst_mid_next: timeout=%b stall=%0d done=%b want 0/2/1", to, st, fd); end
    checks++; if ({fh, fl} !== exp_v) begin failures++; $display("FAIL rst_mid_result: got %h want %h", {fh, fl}, exp_v); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_cancel();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
